// File: rtl/zjh_down_counter.sv
// zjh_down_counter: programmable-modulus synchronous down-counter.
// Counts MODULUS-1 down to 0 and wraps. Supports parallel load with range
// checking and count-enable gating. The combinational borrow C feeds the CET
// input of the next stage to build wider cascades.
module zjh_down_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 14
) (
  input  logic             Clk,
  input  logic             MR,
  input  logic             CEP,
  input  logic             CET,
  input  logic             LD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             C,
  output logic             Zero,
  output logic             LdErr
);

  // The modulus is held one bit wider than the count so that MODULUS = 2^WIDTH
  // can be represented. Range checks are then plain unsigned compares.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] TOP     = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q_next;
  logic             zero_next;
  logic             lderr_next;

  // Next-state selection. At each edge, load takes priority over count, and
  // count takes priority over hold.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    q_next     = Q;
    zero_next  = 1'b0;
    lderr_next = 1'b0;
    if (LD) begin
      if ({1'b0, D} >= MOD_EXT) begin
        q_next     = TOP;
        lderr_next = 1'b1;
      end else begin
        q_next = D;
      end
      zero_next = (q_next == '0);
    end else if (CEP && CET) begin
      if ({1'b0, Q} >= MOD_EXT) begin
        // Out-of-range state is unreachable. It recovers to the top of the range.
        q_next = TOP;
      end else if (Q == '0) begin
        q_next    = TOP;
        zero_next = 1'b1;
      end else begin
        q_next = Q - WIDTH'(1);
      end
    end
  end

  // Counter and flag registers. MR clears them asynchronously to the reset state.
  always_ff @(posedge Clk or posedge MR) begin
    // NOTE: sequential state uses non-blocking assignments so that every register
    // samples values from before the edge, whatever the statement order is.
    if (MR) begin
      Q     <= TOP;
      Zero  <= 1'b0;
      LdErr <= 1'b0;
    end else begin
      Q     <= q_next;
      Zero  <= zero_next;
      LdErr <= lderr_next;
    end
  end

  // Borrow or terminal count. It is combinational so that a cascaded stage sees
  // it in the same cycle.
  assign C = (Q == '0) && CET;

endmodule

// File: tb/tb_zjh_down_counter.sv
// Scoreboard testbench for zjh_down_counter (WIDTH=4, MODULUS=14).
// The stimulus process pushes the expected response for every cycle into a
// queue. A separate monitor pops and compares on each falling edge.
// A two-stage cascade is checked as one combined count value.
module tb_zjh_down_counter;

  localparam int W   = 4;
  localparam int MOD = 14;
  localparam int CASC_TOP = MOD * MOD - 1;

  typedef struct {
    logic [W-1:0] q;
    logic         zero;
    logic         lderr;
    logic         c;
    int           cv;
  } exp_t;

  logic         Clk = 1'b0;
  logic         MR  = 1'b1;
  logic         CEP = 1'b0;
  logic         CET = 1'b0;
  logic         LD  = 1'b0;
  logic [W-1:0] D   = '0;
  logic [W-1:0] Q;
  logic         C, Zero, LdErr;

  // Cascade pair: the low stage's C drives the high stage's CET.
  logic         cas_mr = 1'b1;
  logic         cas_en = 1'b0;
  logic         cas_ld = 1'b0;
  logic [W-1:0] lo_q, hi_q;
  logic         lo_c, hi_c, lo_zero, hi_zero, lo_lderr, hi_lderr;

  zjh_down_counter #(.WIDTH(W), .MODULUS(MOD)) dut (
    .Clk(Clk), .MR(MR), .CEP(CEP), .CET(CET), .LD(LD), .D(D),
    .Q(Q), .C(C), .Zero(Zero), .LdErr(LdErr)
  );

  zjh_down_counter #(.WIDTH(W), .MODULUS(MOD)) u_lo (
    .Clk(Clk), .MR(cas_mr), .CEP(cas_en), .CET(cas_en), .LD(1'b0), .D(4'd0),
    .Q(lo_q), .C(lo_c), .Zero(lo_zero), .LdErr(lo_lderr)
  );

  zjh_down_counter #(.WIDTH(W), .MODULUS(MOD)) u_hi (
    .Clk(Clk), .MR(cas_mr), .CEP(1'b1), .CET(lo_c), .LD(cas_ld), .D(4'd2),
    .Q(hi_q), .C(hi_c), .Zero(hi_zero), .LdErr(hi_lderr)
  );

  always #5 Clk = ~Clk;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  // Reference model state: the counter value and both flags as plain integers.
  int   m_q     = MOD - 1;
  int   m_zero  = 0;
  int   m_lderr = 0;
  int   cas_v   = CASC_TOP;
  bit   mr_prev = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // The rules of the specification, applied to integers.
  task automatic model_edge(input bit mr, input bit ld, input bit cep, input bit cet, input int d);
    if (mr) begin
      m_q = MOD - 1; m_zero = 0; m_lderr = 0;
    end else if (ld) begin
      m_lderr = (d >= MOD) ? 1 : 0;
      m_q     = (d >= MOD) ? MOD - 1 : d;
      m_zero  = (m_q == 0) ? 1 : 0;
    end else if (cep && cet) begin
      m_zero  = (m_q == 0) ? 1 : 0;
      m_q     = (m_q == 0) ? MOD - 1 : m_q - 1;
      m_lderr = 0;
    end else begin
      m_zero = 0; m_lderr = 0;
    end
    // The cascade is one counter of MOD*MOD states, with the high digit loadable.
    if (cas_mr)      cas_v = CASC_TOP;
    else if (cas_ld) cas_v = 2 * MOD + (cas_v % MOD);
    else if (cas_en) cas_v = (cas_v == 0) ? CASC_TOP : cas_v - 1;
  endtask

  // One clock cycle: drive the inputs, push the expected response, then advance the model at the edge.
  task automatic step(input bit mr, input bit ld, input bit cep, input bit cet, input int d);
    exp_t e;
    MR = mr; LD = ld; CEP = cep; CET = cet; D = W'(d);
    if (mr) begin
      m_q = MOD - 1; m_zero = 0; m_lderr = 0;
    end
    if (cas_mr) cas_v = CASC_TOP;
    if (mr && !mr_prev) begin
      #1;
      check("async_reset_q", Q, MOD - 1);
      check("async_reset_c", C, 0);
      check("async_reset_zero", Zero, 0);
      check("async_reset_lderr", LdErr, 0);
    end
    mr_prev = mr;
    e.q     = W'(m_q);
    e.zero  = m_zero[0];
    e.lderr = m_lderr[0];
    e.c     = (m_q == 0) && cet;
    e.cv    = cas_v;
    sb.push_back(e);
    @(posedge Clk);
    model_edge(mr, ld, cep, cet, d);
    #1;
  endtask

  // Monitor: compare the DUT outputs with the next expected response, away from the active edge.
  always @(negedge Clk) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("q", Q, e.q);
      check("zero", Zero, e.zero);
      check("lderr", LdErr, e.lderr);
      check("c", C, e.c);
      check("cascade", int'(hi_q) * MOD + int'(lo_q), e.cv);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge Clk);
    #1;
    // Reset state, held for two cycles.
    step(1, 0, 1, 1, 0);
    step(1, 1, 1, 1, 3);
    // Free run for 30 cycles. Zero should pulse twice.
    for (int i = 0; i < 30; i++) step(0, 0, 1, 1, 0);
    // Loads, including the boundaries D = MOD-1, D = MOD and D = 15.
    step(0, 1, 0, 0, 3);
    step(0, 0, 0, 1, 0);
    step(0, 1, 0, 1, 15);
    step(0, 0, 0, 1, 0);
    step(0, 1, 1, 1, 13);
    step(0, 1, 1, 1, 14);
    step(0, 1, 0, 1, 0);
    // Enable gating at Q = 0.
    step(0, 0, 0, 1, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    // Load together with count enables: the load wins.
    step(0, 1, 1, 1, 7);
    step(0, 1, 1, 1, 9);
    step(0, 0, 1, 1, 0);
    // Async reset in the middle of a count, while Q = 5.
    step(0, 1, 0, 0, 6);
    step(0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 0);
    step(1, 0, 1, 1, 0);
    step(0, 0, 1, 1, 0);
    // Cascade: load the high stage with 2 while the low stage holds, then count.
    cas_mr = 1'b0;
    cas_ld = 1'b1;
    step(0, 0, 1, 1, 0);
    cas_ld = 1'b0;
    cas_en = 1'b1;
    for (int i = 0; i < 48; i++) step(0, 0, 1, 1, 0);
    // Random traffic on the single counter while the cascade keeps running.
    for (int i = 0; i < 400; i++) begin
      automatic bit r_mr  = ($urandom_range(0, 39) == 0);
      automatic bit r_ld  = ($urandom_range(0, 5) == 0);
      automatic bit r_cep = ($urandom_range(0, 3) != 0);
      automatic bit r_cet = ($urandom_range(0, 3) != 0);
      automatic int r_d   = $urandom_range(0, 15);
      if (i % 97 == 50) cas_en = 1'b0;
      if (i % 97 == 60) cas_en = 1'b1;
      step(r_mr, r_ld, r_cep, r_cet, r_d);
    end
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 5 && sb.size() != 0; i++) @(negedge Clk);
    #1;
    if (sb.size() != 0) check("scoreboard_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
